// File: rtl/bcd_pkg.sv
// Shared types and helpers for the streaming BCD decoder.
// The beat length field is wide enough for any MAX_DIGITS up to 255.
package bcd_pkg;

    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam int         BEAT_LEN_W = 8;

    typedef logic [9:0] dec_onehot_t;

    typedef struct packed {
        dec_onehot_t           dec;
        logic                  err;
        logic                  last;
        logic                  trunc;
        logic [BEAT_LEN_W-1:0] len;
    } beat_t;

    function automatic dec_onehot_t bcd2onehot(input logic [3:0] bcd);
        if (bcd > BCD_MAX) return '0;
        return dec_onehot_t'(1) << bcd;
    endfunction

endpackage

// File: rtl/bcd_skid_fifo.sv
// Two-entry valid/ready buffer. Ready depends only on the stored count,
// so there is no combinational path from the pop side to the push side.
module bcd_skid_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] push_data,
    input  logic         push,
    output logic         ready,
    output logic [W-1:0] pop_data,
    output logic         valid,
    input  logic         pop
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         do_push;
    logic         do_pop;

    assign ready    = rst_n & (count != 2'd2);
    assign valid    = (count != 2'd0);
    assign pop_data = valid ? mem[rd_ptr] : '0;
    assign do_push  = push & ready;
    assign do_pop   = pop & valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bcd_dec_stream.sv
// Streaming BCD digit to one-hot decimal decoder with packet length tracking,
// forced termination at MAX_DIGITS and a saturating invalid-digit counter.
//
//  state   | meaning
//  --------+-------------------------------------------------
//  ST_IDLE | between packets; next accepted digit is digit 1
//  ST_BUSY | inside a packet; idx digits already accepted
module bcd_dec_stream
    import bcd_pkg::*;
#(
    parameter int MAX_DIGITS = 8,
    parameter int ERR_CNT_W  = 8,
    localparam int LEN_W     = $clog2(MAX_DIGITS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           in_bcd,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [9:0]           out_dec,
    output logic                 out_err,
    output logic                 out_last,
    output logic                 out_trunc,
    output logic [LEN_W-1:0]     out_len,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]       state;
    logic [LEN_W-1:0] idx;
    logic [LEN_W-1:0] idx_base;
    logic [LEN_W-1:0] idx_inc;
    logic             at_max;
    logic             end_pkt;
    logic             accept;
    logic             dig_err;
    beat_t            beat_in;
    beat_t            beat_out;

    assign accept   = in_valid & in_ready;
    assign dig_err  = (in_bcd > BCD_MAX);
    assign idx_base = (state == ST_IDLE) ? '0 : idx;
    assign idx_inc  = idx_base + LEN_W'(1);
    assign at_max   = (idx_inc == LEN_W'(MAX_DIGITS));
    assign end_pkt  = in_last | at_max;

    always_comb begin
        beat_in       = '0;
        beat_in.dec   = bcd2onehot(in_bcd);
        beat_in.err   = dig_err;
        beat_in.last  = end_pkt;
        beat_in.trunc = ~in_last & at_max;
        beat_in.len   = end_pkt ? BEAT_LEN_W'(idx_inc) : '0;
    end

    // Invalid digits occupy a slot in the packet like any other digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else if (accept) begin
            if (end_pkt) begin
                state <= ST_IDLE;
                idx   <= '0;
            end else begin
                state <= ST_BUSY;
                idx   <= idx_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (accept && dig_err && !(&err_cnt)) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end

    bcd_skid_fifo #(
        .W($bits(beat_t))
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_data(beat_in),
        .push     (in_valid),
        .ready    (in_ready),
        .pop_data (beat_out),
        .valid    (out_valid),
        .pop      (out_ready)
    );

    logic unused_len_hi;
    assign unused_len_hi = ^beat_out.len[BEAT_LEN_W-1:LEN_W];

    assign out_dec   = beat_out.dec;
    assign out_err   = beat_out.err;
    assign out_last  = beat_out.last;
    assign out_trunc = beat_out.trunc;
    assign out_len   = beat_out.len[LEN_W-1:0];

endmodule

// File: tb/tb_bcd_dec_stream.sv
// Directed and randomised bench for bcd_dec_stream: a queue-based reference
// model checked on every output handshake, plus literal expectations per scenario.
module tb_bcd_dec_stream;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] in_bcd = 4'd0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic [9:0] out_dec;
    logic       out_err;
    logic       out_last;
    logic       out_trunc;
    logic [3:0] out_len;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       err_clr = 1'b0;
    logic [7:0] err_cnt;

    bcd_dec_stream #(.MAX_DIGITS(8), .ERR_CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_bcd   (in_bcd),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .out_dec  (out_dec),
        .out_err  (out_err),
        .out_last (out_last),
        .out_trunc(out_trunc),
        .out_len  (out_len),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .err_clr  (err_clr),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] dec;
        logic       err;
        logic       last;
        logic       trunc;
        int         len;
    } exp_t;

    exp_t q[$];
    exp_t e_pop;
    exp_t e_push;
    int   m_pkt;
    int   m_err;
    int   checks = 0;
    int   fails = 0;
    bit   rand_rdy = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: evaluated mid-cycle, where inputs and outputs are stable.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_pkt = 0;
            m_err = 0;
        end else begin
            chk("err_cnt", 32'(err_cnt), 32'(m_err));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL spurious_beat: got out_dec %0h expected no beat", out_dec);
                end else begin
                    e_pop = q.pop_front();
                    chk("dec",   32'(out_dec),   32'(e_pop.dec));
                    chk("err",   32'(out_err),   32'(e_pop.err));
                    chk("last",  32'(out_last),  32'(e_pop.last));
                    chk("trunc", 32'(out_trunc), 32'(e_pop.trunc));
                    chk("len",   32'(out_len),   32'(e_pop.len));
                end
            end
            if (in_valid && in_ready) begin
                m_pkt++;
                e_push.dec   = (in_bcd <= 4'd9) ? (10'd1 << in_bcd) : 10'd0;
                e_push.err   = (in_bcd > 4'd9);
                e_push.last  = in_last || (m_pkt == 8);
                e_push.trunc = !in_last && (m_pkt == 8);
                e_push.len   = e_push.last ? m_pkt : 0;
                if (e_push.last) m_pkt = 0;
                q.push_back(e_push);
            end
            if (err_clr) m_err = 0;
            else if (in_valid && in_ready && in_bcd > 4'd9 && m_err < 255) m_err++;
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1 out_ready = ($urandom_range(0, 9) < 7);
        end
    end

    task automatic send(input logic [3:0] d, input logic l);
        int n;
        in_bcd   = d;
        in_last  = l;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            fails++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_dec",   32'(out_dec),   32'd0);
        chk("rst_out_len",   32'(out_len),   32'd0);
        chk("rst_err_cnt",   32'(err_cnt),   32'd0);
        #10 rst_n = 1'b1;
        step(1);

        // 1: packet 3,0,9 with one-cycle latency
        chk("t1_empty", 32'(out_valid), 32'd0);
        send(4'd3, 1'b0);
        chk("t1_v0", 32'(out_valid), 32'd1);
        chk("t1_d0", 32'(out_dec), 32'h008);
        send(4'd0, 1'b0);
        chk("t1_d1", 32'(out_dec), 32'h001);
        chk("t1_l1", 32'(out_last), 32'd0);
        send(4'd9, 1'b1);
        chk("t1_d2", 32'(out_dec), 32'h200);
        chk("t1_last", 32'(out_last), 32'd1);
        chk("t1_len", 32'(out_len), 32'd3);
        chk("t1_trunc", 32'(out_trunc), 32'd0);
        step(1);

        // 2: invalid digit and err_clr priority
        send(4'd12, 1'b1);
        chk("t2_dec", 32'(out_dec), 32'h000);
        chk("t2_err", 32'(out_err), 32'd1);
        chk("t2_len", 32'(out_len), 32'd1);
        chk("t2_cnt", 32'(err_cnt), 32'd1);
        err_clr = 1'b1;
        send(4'd13, 1'b1);
        err_clr = 1'b0;
        chk("t2_clr", 32'(err_cnt), 32'd0);
        step(1);

        // 3: forced termination at 8 digits
        for (int i = 1; i <= 9; i++) begin
            send(4'd5, 1'b0);
            if (i == 8) begin
                chk("t3_last8", 32'(out_last), 32'd1);
                chk("t3_trunc8", 32'(out_trunc), 32'd1);
                chk("t3_len8", 32'(out_len), 32'd8);
            end else if (i == 9) begin
                chk("t3_last9", 32'(out_last), 32'd0);
                chk("t3_len9", 32'(out_len), 32'd0);
            end
        end
        send(4'd5, 1'b1);
        chk("t3_len_new", 32'(out_len), 32'd2);
        chk("t3_trunc_new", 32'(out_trunc), 32'd0);
        step(1);

        // 4: backpressure holds output and blocks input
        out_ready = 1'b0;
        send(4'd1, 1'b0);
        send(4'd2, 1'b1);
        chk("t4_rdy", 32'(in_ready), 32'd0);
        chk("t4_hold0", 32'(out_dec), 32'h002);
        step(3);
        chk("t4_hold3", 32'(out_dec), 32'h002);
        chk("t4_rdy3", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        step(1);
        chk("t4_second", 32'(out_dec), 32'h004);
        chk("t4_len", 32'(out_len), 32'd2);
        step(1);
        chk("t4_empty", 32'(out_valid), 32'd0);

        // 5: reset mid-packet with two beats buffered
        out_ready = 1'b0;
        send(4'd11, 1'b0);
        send(4'd8, 1'b0);
        chk("t5_cnt_pre", 32'(err_cnt), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_cnt", 32'(err_cnt), 32'd0);
        chk("t5_rdy", 32'(in_ready), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        step(2);
        chk("t5_no_beat", 32'(out_valid), 32'd0);
        send(4'd4, 1'b1);
        chk("t5_dec", 32'(out_dec), 32'h010);
        chk("t5_len", 32'(out_len), 32'd1);
        step(1);

        // 6: random traffic against the model
        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            step($urandom_range(0, 2));
            err_clr = ($urandom_range(0, 40) == 0);
            send(4'($urandom_range(0, 15)), ($urandom_range(0, 5) == 0));
            err_clr = 1'b0;
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        for (int n = 0; n < 20 && (q.size() != 0 || out_valid); n++) step(1);
        chk("t6_drain", 32'(q.size()), 32'd0);

        // Saturation of the error counter
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        for (int i = 0; i < 260; i++) send(4'd15, (i % 8) == 7);
        step(1);
        chk("sat_cnt", 32'(err_cnt), 32'hFF);

        step(2);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
